// File: rtl/calc_sequencer.sv
// Two-requester round-robin front end for the signed NB-bit calculator (add/sub/mul/div/pow).
// Define CALC_SEQ_DIV_EN to build the divider; otherwise opcode 3 reports an illegal opcode.
module calc_sequencer #(
  parameter int NB = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [NB-1:0] req0_a,
  input  logic [NB-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [NB-1:0] req1_a,
  input  logic [NB-1:0] req1_b,
  input  logic [2:0]    req1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [NB-1:0] rsp_result,
  output logic [1:0]    rsp_err,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] POW  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [NB-1:0] ONE  = {{(NB-1){1'b0}}, 1'b1};
  localparam logic [NB-1:0] MINV = {1'b1, {(NB-1){1'b0}}};

  typedef struct packed {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [2:0]    op;
  } req_t;

  logic [1:0]    state;
  logic          last;
  req_t          sel, cur;
  logic [NB-1:0] acc, base, e, prod, ex_res;
  logic [1:0]    ex_err;
  logic          g0, g1, pow_start, pow_last;

  // last holds the requester served most recently; ties go to the other one
  assign g0 = req0_valid & (~req1_valid | last);
  assign g1 = req1_valid & (~req0_valid | ~last);
  assign req0_ready = (state == IDLE) & g0;
  assign req1_ready = (state == IDLE) & g1;
  assign busy = (state != IDLE);

  assign sel = g1 ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op};
  assign pow_start = (sel.op == 3'd4) & ~sel.b[NB-1] & (|sel.b);
  assign prod = acc * base;
  assign pow_last = ~|e[NB-1:1];

  always_comb begin
    ex_res = '0;
    ex_err = 2'd0;
    case (cur.op)
      3'd0: ex_res = cur.a + cur.b;
      3'd1: ex_res = cur.a - cur.b;
      3'd2: ex_res = cur.a * cur.b;
      3'd3: begin
`ifdef CALC_SEQ_DIV_EN
        if (cur.b == '0) ex_err = 2'd1;
        else if (cur.a == MINV && cur.b == '1) ex_res = MINV;
        else ex_res = $signed(cur.a) / $signed(cur.b);
`else
        ex_err = 2'd3;
`endif
      end
      // positive exponents run through POW; only b<=0 lands here
      3'd4: begin
        if (cur.b[NB-1]) ex_err = 2'd2;
        else ex_res = ONE;
      end
      default: ex_err = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 2'd0;
      cur        <= '0;
      acc        <= '0;
      base       <= '0;
      e          <= '0;
    end else begin
      case (state)
        IDLE: if (g0 | g1) begin
          cur    <= sel;
          rsp_id <= g1;
          acc    <= ONE;
          base   <= sel.a;
          e      <= sel.b;
          state  <= pow_start ? POW : EXEC;
        end
        EXEC: begin
          rsp_result <= ex_res;
          rsp_err    <= ex_err;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        POW: begin
          if (e[0]) acc <= prod;
          base <= base * base;
          e    <= e >> 1;
          if (pow_last) begin
            rsp_result <= e[0] ? prod : acc;
            rsp_err    <= 2'd0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          last      <= rsp_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized bench for calc_sequencer: a per-cycle scoreboard predicts grants, latency and
// responses from plain arithmetic, plus directed literal checks of the documented cases.
module tb_calc_sequencer;
  localparam int NB = 40;
  typedef logic [NB-1:0] w_t;
  localparam w_t MINV = {1'b1, {(NB-1){1'b0}}};

  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  w_t req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic rsp_valid, rsp_ready, rsp_id, busy;
  w_t rsp_result;
  logic [1:0] rsp_err;

  int n_vec = 0, n_err = 0, n_chk = 0, rsp_cnt = 0;
  w_t last_res;
  logic [1:0] last_err;
  logic last_id;

  calc_sequencer #(.NB(NB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic w_t ipow(w_t a, w_t b);
    w_t r = w_t'(1);
    w_t x = a;
    if (b < w_t'(64)) begin
      for (int i = 0; i < int'(b); i++) r = r * a;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b[i]) r = r * x;
        x = x * x;
      end
    end
    return r;
  endfunction

  function automatic logic [NB+1:0] model(logic [2:0] op, w_t a, w_t b);
    w_t res = '0;
    logic [1:0] err = 2'd0;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = a * b;
      3'd3: begin
`ifdef CALC_SEQ_DIV_EN
        if (b == '0) err = 2'd1;
        else if (a == MINV && b == '1) res = MINV;
        else res = w_t'($signed(a) / $signed(b));
`else
        err = 2'd3;
`endif
      end
      3'd4: if (b[NB-1]) err = 2'd2; else res = ipow(a, b);
      default: err = 2'd3;
    endcase
    return {err, res};
  endfunction

  function automatic int bitlen(w_t b);
    int l = 0;
    for (int i = 0; i < NB; i++) if (b[i]) l = i + 1;
    return l;
  endfunction

  function automatic int lat(logic [2:0] op, w_t b);
    if (op == 3'd4 && !b[NB-1] && b != '0) return 1 + bitlen(b);
    return 2;
  endfunction

  // Scoreboard: one abstract "idle / waiting for response" flag per cycle.
  initial begin : mon
    bit idle = 1'b1, lastp = 1'b1, rstd = 1'b1, g0, g1;
    int nc = 0, due = 0;
    logic eid;
    w_t eres;
    logic [1:0] eerr;
    logic [NB+1:0] m;
    forever begin
      @(negedge clk);
      nc++;
      if (rst) begin
        idle = 1'b1; lastp = 1'b1; rstd = 1'b1;
      end else begin
        if (rstd) begin
          chk("rst_busy", busy, 0);
          chk("rst_rsp_valid", rsp_valid, 0);
          chk("rst_rsp_id", rsp_id, 0);
          chk("rst_rsp_result", rsp_result, 0);
          chk("rst_rsp_err", rsp_err, 0);
          rstd = 1'b0;
        end
        if (idle) begin
          g0 = req0_valid && (!req1_valid || lastp);
          g1 = req1_valid && (!req0_valid || !lastp);
          chk("req0_ready", req0_ready, g0);
          chk("req1_ready", req1_ready, g1);
          chk("idle_busy", busy, 0);
          chk("idle_rsp_valid", rsp_valid, 0);
          if (g0 || g1) begin
            eid = g1;
            m = g1 ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
            {eerr, eres} = m;
            due = nc + (g1 ? lat(req1_op, req1_b) : lat(req0_op, req0_b));
            idle = 1'b0;
            n_vec++;
          end
        end else begin
          chk("busy_req0_ready", req0_ready, 0);
          chk("busy_req1_ready", req1_ready, 0);
          chk("busy", busy, 1);
          if (nc < due) begin
            chk("early_rsp_valid", rsp_valid, 0);
          end else begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, eid);
            chk("rsp_result", rsp_result, eres);
            chk("rsp_err", rsp_err, eerr);
            if (rsp_ready) begin
              last_res = rsp_result; last_err = rsp_err; last_id = rsp_id;
              rsp_cnt++;
              idle = 1'b1;
              lastp = eid;
            end
          end
        end
      end
    end
  end

  task automatic drive(bit id, logic [2:0] op, w_t a, w_t b);
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
  endtask

  task automatic issue(bit id, logic [2:0] op, w_t a, w_t b);
    drive(id, op, a, b);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        return;
      end
    end
    fail_timeout("issue_handshake");
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic expect_rsp(string nm, logic id, w_t res, logic [1:0] err);
    int c0 = rsp_cnt;
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (rsp_cnt != c0) got = 1'b1;
    end
    if (!got) fail_timeout({nm, "_rsp"});
    else begin
      chk({nm, "_id"}, last_id, id);
      chk({nm, "_result"}, last_res, res);
      chk({nm, "_err"}, last_err, err);
    end
  endtask

  function automatic w_t rnd_val();
    case ($urandom % 5)
      0: return w_t'($urandom_range(0, 40)) - w_t'(20);
      1: return MINV;
      2: return '1;
      3: return '0;
      default: return w_t'({$urandom, $urandom});
    endcase
  endfunction

  task automatic gen(bit mul_only, output logic [2:0] op, output w_t a, output w_t b);
    op = mul_only ? 3'd2 : 3'($urandom % 8);
    a = rnd_val();
    b = rnd_val();
    if (op == 3'd4) b = w_t'($urandom_range(0, 48)) - w_t'(3);
  endtask

  task automatic run_rand(int ncyc, bit mul_only, bit both, bit rnd_ready);
    bit h0, h1;
    logic [2:0] op;
    w_t a, b;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0 || !req0_valid) begin
        if (both || ($urandom % 2) == 1) begin gen(mul_only, op, a, b); drive(1'b0, op, a, b); end
        else req0_valid = 1'b0;
      end
      if (h1 || !req1_valid) begin
        if (both || ($urandom % 2) == 1) begin gen(mul_only, op, a, b); drive(1'b1, op, a, b); end
        else req1_valid = 1'b0;
      end
      rsp_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;

    chk("pin_add", model(3'd0, w_t'(5), w_t'(-7)), {2'd0, w_t'(-2)});
    chk("pin_pow", model(3'd4, w_t'(3), w_t'(13)), {2'd0, w_t'(1594323)});
    chk("pin_pow_wrap", model(3'd4, w_t'(2), w_t'(40)), {2'd0, w_t'(0)});
    chk("pin_lat13", lat(3'd4, w_t'(13)), 5);
    chk("pin_lat40", lat(3'd4, w_t'(40)), 7);
    chk("pin_lat_add", lat(3'd0, w_t'(40)), 2);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b0, 3'd0, w_t'(5), w_t'(-7));
    expect_rsp("add", 1'b0, w_t'(-2), 2'd0);

    run_rand(40, 1'b1, 1'b1, 1'b0);

    issue(1'b1, 3'd4, w_t'(3), w_t'(13));
    expect_rsp("pow3_13", 1'b1, w_t'(1594323), 2'd0);
    issue(1'b1, 3'd4, w_t'(2), w_t'(40));
    expect_rsp("pow2_40", 1'b1, w_t'(0), 2'd0);
    issue(1'b1, 3'd4, w_t'(-2), w_t'(0));
    expect_rsp("pow_b0", 1'b1, w_t'(1), 2'd0);

`ifdef CALC_SEQ_DIV_EN
    issue(1'b0, 3'd3, w_t'(-7), w_t'(2));
    expect_rsp("div", 1'b0, w_t'(-3), 2'd0);
    issue(1'b0, 3'd3, w_t'(9), w_t'(0));
    expect_rsp("div0", 1'b0, w_t'(0), 2'd1);
    issue(1'b0, 3'd3, MINV, w_t'(-1));
    expect_rsp("div_min", 1'b0, MINV, 2'd0);
`else
    issue(1'b0, 3'd3, w_t'(-7), w_t'(2));
    expect_rsp("div", 1'b0, w_t'(0), 2'd3);
    issue(1'b0, 3'd3, w_t'(9), w_t'(0));
    expect_rsp("div0", 1'b0, w_t'(0), 2'd3);
    issue(1'b0, 3'd3, MINV, w_t'(-1));
    expect_rsp("div_min", 1'b0, w_t'(0), 2'd3);
`endif

    issue(1'b0, 3'd4, w_t'(5), w_t'(-1));
    expect_rsp("pow_neg", 1'b0, w_t'(0), 2'd2);

    rsp_ready = 1'b0;
    issue(1'b0, 3'd6, w_t'(1), w_t'(2));
    drive(1'b1, 3'd0, w_t'(7), w_t'(8));
    repeat (7) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    expect_rsp("illegal_op", 1'b0, w_t'(0), 2'd3);
    issue(1'b1, 3'd0, w_t'(7), w_t'(8));
    expect_rsp("after_hold", 1'b1, w_t'(15), 2'd0);

    run_rand(1500, 1'b0, 1'b0, 1'b1);

    issue(1'b0, 3'd4, w_t'(3), w_t'(40'h40_0000_0000));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("pow_reset_busy", busy, 0);
    chk("pow_reset_rsp_valid", rsp_valid, 0);
    repeat (30) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Multi-cycle, two-requester front end for the signed NB-bit calculator datapath (add, sub, mul, div, power). Arbitrates two requesters round-robin over valid/ready, executes one operation at a time, and returns a tagged result plus error code over a valid/ready response channel. Power is computed iteratively by square-and-multiply, one step per cycle, instead of a combinational `**`. Sits between the control/host logic and the arithmetic core as its only access path.

## Interface
- NB, 40, operand/result width in bits (two's-complement signed)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when high with valid
- req0_a, req0_b  in  NB  signed operands, requester 0
- req0_op  in  3  opcode, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index that issued the operation
- rsp_result  out  NB  signed result
- rsp_err  out  2  0 ok, 1 divide by zero, 2 negative exponent, 3 illegal opcode
- busy  out  1  high in every state except IDLE

## Operation
- Opcodes: 0 a+b, 1 a−b, 2 a*b, 3 a/b, 4 a**b, 5–7 illegal.
- All arithmetic is modulo 2^NB (low NB bits kept, no saturation, no overflow flag).
- Division truncates toward zero. Most-negative / −1 yields most-negative.
- States: IDLE, EXEC, POW, RESP.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to the one not served last.
  - The pointer resets so requester 0 wins the first tie.
  - req*_ready is high only for the granted requester and only in IDLE.
  - On handshake: capture a, b, op and id.
  - Go to POW if op==4 and b>0; otherwise go to EXEC.
- EXEC (1 cycle): register the result and error, then go to RESP.
  - On any error, rsp_result = 0.
  - Division with b==0 gives err 1.
  - Power with b<0 gives err 2.
  - Opcodes 5–7 give err 3.
  - Power with b==0 gives 1 with err 0, including 0**0.
- POW: accumulator starts at 1, base = a, exponent register e = b.
  - Each cycle: if e[0], acc ← acc*base; base ← base*base; e ← e>>1.
  - Go to RESP after the cycle in which e>>1 == 0.
- RESP:
  - rsp_valid is high, and rsp_id, rsp_result and rsp_err are held stable until rsp_ready.
  - On handshake, go to IDLE and update the round-robin pointer to rsp_id.
  - No request is accepted while in RESP.
- Reset in any state: return to IDLE immediately. The in-flight operation is dropped and no response is produced.

## Timing
- Reset values:
  - rsp_valid 0, req0_ready 0, req1_ready 0, busy 0
  - rsp_id 0, rsp_result 0, rsp_err 0
  - pointer set so requester 0 is preferred
- req*_ready is first asserted the cycle after rst deasserts.
- Latency from request handshake at edge T:
  - Non-POW operations: rsp_valid rises at T+2.
  - POW: rsp_valid rises at T+1+bitlen(b), where bitlen(b) is the position of the highest set bit plus 1.
  - Worst case POW latency is NB cycles.
- With rsp_ready held high, the next request handshake can occur in the cycle after the response handshake. Peak throughput is one operation per 3 cycles.
- Requester inputs are sampled only at the handshake. Changes after acceptance have no effect.
- rsp_* outputs come directly from registers. req*_ready is decoded from state and pointer, with a combinational path from req*_valid only.

## Configuration
- CALC_SEQ_DIV_EN defined: opcode 3 performs division as specified above.
- CALC_SEQ_DIV_EN undefined:
  - No divider is synthesized.
  - Opcode 3 is treated as illegal: err 3, result 0, including when b==0.
  - Latency is unchanged.

## Test plan
- Reset, then req0 op0 a=5 b=−7 → ready at first post-reset cycle; rsp at T+2: result −2, err 0, id 0.
- req0 and req1 valid every cycle with op2, rsp_ready=1 → grants alternate 0,1,0,1; each result matches a*b mod 2^40.
- req1 op4 a=3 b=13 → rsp at T+5, result 1594323, err 0. Then a=2 b=40 → result 0 at T+7. Then a=−2 b=0 → result 1.
- op3 a=−7 b=2 → −3. Then a=9 b=0 → err 1, result 0. Then a=−2^39 b=−1 → −2^39. Without CALC_SEQ_DIV_EN, all three return err 3.
- op4 b=−1 → err 2. Op 6 → err 3. Hold rsp_ready=0 for 5 cycles → rsp fields stable, no req*_ready.
- Assert rst during POW (a=3 b=2^38) → next cycle busy 0 and rsp_valid 0; no stale response after reset release.
